// File: rtl/traffic_light_ctrl.sv
// Phase sequencer for one traffic-light approach: drives the countdown counter's
// load/enable, decodes lamps and walk from the state, and adds a yellow-flash mode.
module traffic_light_ctrl #(
    parameter int unsigned pGREEN_INIT_VAL = 14,
    parameter int unsigned pMIN_GREEN      = 4,
    parameter int unsigned pCNT_WIDTH      = 5,
    parameter int unsigned pINIT_WIDTH     = 3,
    parameter int unsigned pFLASH_HALF     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   ped_req,
    input  logic                   flash_req,
    input  logic                   cnt_last,
    input  logic [pCNT_WIDTH-1:0]  cnt_value,
    output logic [pINIT_WIDTH-1:0] init,
    output logic                   cnt_en,
    output logic                   green,
    output logic                   yellow,
    output logic                   red,
    output logic                   ped_walk,
    output logic [2:0]             phase
);

    localparam bit EARLY_EN = (pMIN_GREEN < pGREEN_INIT_VAL);
    localparam logic [pCNT_WIDTH-1:0] EARLY_THRESH =
        EARLY_EN ? pCNT_WIDTH'(pGREEN_INIT_VAL - pMIN_GREEN) : '0;
    localparam int unsigned FLASH_W = (pFLASH_HALF > 1) ? $clog2(pFLASH_HALF) : 1;
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(pFLASH_HALF - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        G_LD  = 3'd1,
        G_RUN = 3'd2,
        Y_LD  = 3'd3,
        Y_RUN = 3'd4,
        R_LD  = 3'd5,
        R_RUN = 3'd6,
        FLASH = 3'd7
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 ped_pending;
    logic [FLASH_W-1:0]   flash_cnt;
    logic                 flash_on;
    logic                 early_exit;

    assign early_exit = EARLY_EN && ped_pending && (cnt_value <= EARLY_THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flash_req) begin
            next_state = FLASH;
        end else begin
            unique case (state)
                IDLE:    if (run) next_state = G_LD;
                G_LD:    next_state = G_RUN;
                G_RUN:   if (cnt_last || early_exit) next_state = Y_LD;
                Y_LD:    next_state = Y_RUN;
                Y_RUN:   if (cnt_last) next_state = R_LD;
                R_LD:    next_state = R_RUN;
                R_RUN:   if (cnt_last) next_state = run ? G_LD : IDLE;
                FLASH:   next_state = R_LD;
                default: next_state = IDLE;
            endcase
        end
    end

    // A request arriving in the same cycle as the yellow entry survives for the next green.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end else if (state == G_RUN && next_state == Y_LD) begin
            ped_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_cnt <= '0;
            flash_on  <= 1'b1;
        end else if (state == FLASH) begin
            if (flash_cnt == FLASH_LAST) begin
                flash_cnt <= '0;
                flash_on  <= ~flash_on;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end else begin
            flash_cnt <= '0;
            flash_on  <= 1'b1;
        end
    end

    always_comb begin
        init     = '0;
        cnt_en   = 1'b0;
        green    = 1'b0;
        yellow   = 1'b0;
        red      = 1'b0;
        ped_walk = 1'b0;
        phase    = state;
        unique case (state)
            IDLE:  red = 1'b1;
            G_LD:  begin init[0] = 1'b1; cnt_en = 1'b1; green = 1'b1; end
            G_RUN: begin cnt_en = 1'b1; green = 1'b1; end
            Y_LD:  begin init[1] = 1'b1; cnt_en = 1'b1; yellow = 1'b1; end
            Y_RUN: begin cnt_en = 1'b1; yellow = 1'b1; end
            R_LD:  begin init[2] = 1'b1; cnt_en = 1'b1; red = 1'b1; end
            R_RUN: begin cnt_en = 1'b1; red = 1'b1; ped_walk = 1'b1; end
            FLASH: yellow = flash_on;
            default: red = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: a behavioural countdown counter feeds
// the DUT, and a phase/age reference model predicts every output each cycle.
module tb_traffic_light_ctrl;

    localparam int GREEN_DUR  = 14;
    localparam int YELLOW_DUR = 2;
    localparam int RED_DUR    = 17;
    localparam int MIN_GREEN  = 4;
    localparam int FLASH_HALF = 8;
    localparam int CW         = 5;

    localparam int C_IDLE   = 0;
    localparam int C_GREEN  = 1;
    localparam int C_YELLOW = 2;
    localparam int C_RED    = 3;
    localparam int C_FLASH  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          ped_req = 1'b0;
    logic          flash_req = 1'b0;
    logic          cnt_last;
    logic [CW-1:0] cnt_value;
    logic [2:0]    init;
    logic          cnt_en;
    logic          green;
    logic          yellow;
    logic          red;
    logic          ped_walk;
    logic [2:0]    phase;

    int error_count = 0;
    int check_count = 0;

    // Reference model: current lamp colour, cycles spent in it, pending walk request.
    int m_color = C_IDLE;
    int m_age = 0;
    int m_flash_age = 0;
    bit m_pending = 1'b0;
    int n_color;
    int n_age;
    int n_flash_age;
    bit n_pending;

    logic [CW-1:0] env_count;

    always #5 clk = ~clk;

    // Stand-in for the countdown counter that sits below the controller.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            env_count <= '0;
        end else if (cnt_en) begin
            if (init[0])      env_count <= CW'(GREEN_DUR);
            else if (init[1]) env_count <= CW'(YELLOW_DUR);
            else if (init[2]) env_count <= CW'(RED_DUR);
            else              env_count <= env_count - 1'b1;
        end
    end

    assign cnt_value = env_count;
    assign cnt_last  = (env_count == '0);

    traffic_light_ctrl #(
        .pGREEN_INIT_VAL(GREEN_DUR),
        .pMIN_GREEN     (MIN_GREEN),
        .pCNT_WIDTH     (CW),
        .pINIT_WIDTH    (3),
        .pFLASH_HALF    (FLASH_HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .ped_req  (ped_req),
        .flash_req(flash_req),
        .cnt_last (cnt_last),
        .cnt_value(cnt_value),
        .init     (init),
        .cnt_en   (cnt_en),
        .green    (green),
        .yellow   (yellow),
        .red      (red),
        .ped_walk (ped_walk),
        .phase    (phase)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed != expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int durOf(input int color);
        if (color == C_GREEN)  return GREEN_DUR;
        if (color == C_YELLOW) return YELLOW_DUR;
        return RED_DUR;
    endfunction

    task automatic checkAll();
        int  exp_phase;
        int  exp_init;
        int  exp_lamps;
        bit  lit_phase;
        lit_phase = (m_color >= C_GREEN) && (m_color <= C_RED);
        if (m_color == C_IDLE)       exp_phase = 0;
        else if (m_color == C_FLASH) exp_phase = 7;
        else                         exp_phase = 2 * m_color - 1 + ((m_age > 0) ? 1 : 0);
        exp_init = (lit_phase && m_age == 0) ? (1 << (m_color - 1)) : 0;
        case (m_color)
            C_GREEN:  exp_lamps = 4;
            C_YELLOW: exp_lamps = 2;
            C_FLASH:  exp_lamps = (((m_flash_age / FLASH_HALF) % 2) == 0) ? 2 : 0;
            default:  exp_lamps = 1;
        endcase
        checkOutput("phase",  int'(phase), exp_phase);
        checkOutput("init",   int'(init), exp_init);
        checkOutput("cnt_en", int'(cnt_en), lit_phase ? 1 : 0);
        checkOutput("lamps_gyr", int'({green, yellow, red}), exp_lamps);
        checkOutput("ped_walk", int'(ped_walk), (m_color == C_RED && m_age > 0) ? 1 : 0);
    endtask

    task automatic modelReset();
        m_color = C_IDLE;
        m_age = 0;
        m_flash_age = 0;
        m_pending = 1'b0;
    endtask

    task automatic modelStep();
        int remaining;
        bit done;
        n_color = m_color;
        n_age = m_age;
        n_flash_age = 0;
        n_pending = ped_req ? 1'b1 : m_pending;
        if (rst) begin
            n_color = C_IDLE;
            n_age = 0;
            n_pending = 1'b0;
        end else if (flash_req) begin
            n_color = C_FLASH;
            n_age = 0;
            n_flash_age = (m_color == C_FLASH) ? m_flash_age + 1 : 0;
        end else if (m_color == C_IDLE) begin
            if (run) begin
                n_color = C_GREEN;
                n_age = 0;
            end
        end else if (m_color == C_FLASH) begin
            n_color = C_RED;
            n_age = 0;
        end else if (m_age == 0) begin
            n_age = 1;
        end else begin
            remaining = durOf(m_color) - (m_age - 1);
            done = (remaining == 0) ||
                   (m_color == C_GREEN && m_pending && MIN_GREEN < GREEN_DUR &&
                    remaining <= GREEN_DUR - MIN_GREEN);
            if (done) begin
                n_age = 0;
                if (m_color == C_GREEN) begin
                    n_color = C_YELLOW;
                    if (!ped_req) n_pending = 1'b0;
                end else if (m_color == C_YELLOW) begin
                    n_color = C_RED;
                end else begin
                    n_color = run ? C_GREEN : C_IDLE;
                end
            end else begin
                n_age = m_age + 1;
            end
        end
    endtask

    // One clock: check at the falling edge, drive inputs, advance the model past the rising edge.
    task automatic applyStimulus(input logic rs, input logic r, input logic p, input logic f);
        @(negedge clk);
        checkAll();
        rst = rs;
        run = r;
        ped_req = p;
        flash_req = f;
        modelStep();
        @(posedge clk);
        #1;
        m_color = n_color;
        m_age = n_age;
        m_flash_age = n_flash_age;
        m_pending = n_pending;
    endtask

    task automatic waitFor(input int color, input int age);
        int n;
        n = 0;
        while (!(m_color == color && m_age == age) && n < 200) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        checkOutput("wait_reached", (m_color == color && m_age == age) ? 1 : 0, 1);
    endtask

    initial begin
        bit flash_state;
        modelReset();
        #1;
        checkAll();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        // Full uninterrupted period and a bit.
        repeat (45) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        // Walk button in the first G_RUN cycle cuts green short.
        waitFor(C_GREEN, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        // Button held across the yellow load keeps the request for the next green.
        waitFor(C_YELLOW, 0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (60) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        // Dropping run mid-green finishes the cycle, then parks in red.
        waitFor(C_GREEN, 3);
        repeat (50) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        // Maintenance flash entered mid-yellow, then restart through red.
        waitFor(C_YELLOW, 2);
        repeat (40) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (25) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-red must take effect before the next clock.
        waitFor(C_RED, 5);
        @(negedge clk);
        checkAll();
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        flash_state = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 79) == 0) flash_state = ~flash_state;
            applyStimulus($urandom_range(0, 999) == 0,
                          $urandom_range(0, 15) != 0,
                          $urandom_range(0, 19) == 0,
                          flash_state);
        end

        @(negedge clk);
        checkAll();
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Phase sequencer for one traffic-light approach. It drives the countdown counter's `init` load pulses and `cnt_en`, and consumes its `last` and `count_out` outputs. From those it produces the green/yellow/red lamp outputs, a pedestrian walk signal and a yellow-flash maintenance mode. It sits directly above the counter in the intersection design; the counter holds the phase durations and this block holds the phase order.

## Interface
- `pGREEN_INIT_VAL`, 14: green duration loaded into the counter. Used here only for the pedestrian early-exit threshold.
- `pMIN_GREEN`, 4: minimum green counts elapsed before a pedestrian request may cut green short.
- `pCNT_WIDTH`, 5: width of `cnt_value`.
- `pINIT_WIDTH`, 3: width of `init`. Bit 0 = green, bit 1 = yellow, bit 2 = red.
- `pFLASH_HALF`, 8: cycles per half-period of the flashing yellow lamp.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: 1 = cycle the phases, 0 = park in all-red after the current red phase.
- `ped_req` in 1: pedestrian button, level or pulse. It is latched internally.
- `flash_req` in 1: maintenance mode, yellow flashing.
- `cnt_last` in 1: counter `last`, high when count == 0.
- `cnt_value` in pCNT_WIDTH: counter `count_out`.
- `init` out pINIT_WIDTH: one-hot, one-cycle load pulse to the counter.
- `cnt_en` out 1: counter enable.
- `green`, `yellow`, `red` out 1 each: lamp drives.
- `ped_walk` out 1: walk signal.
- `phase` out 3: state code for debug. IDLE=0, G_LD=1, G_RUN=2, Y_LD=3, Y_RUN=4, R_LD=5, R_RUN=6, FLASH=7.

## Operation
- Counter contract: when `init[i]` and `cnt_en` are both high at an edge, the counter loads that phase's duration. When only `cnt_en` is high, it decrements. The controller therefore holds `cnt_en`=1 in every LD and RUN state.
- States and outputs:
  - IDLE: red=1. `init`=0, `cnt_en`=0.
  - X_LD: `init`=one-hot for phase X, `cnt_en`=1, and phase X's lamp is on.
  - X_RUN: `init`=0, `cnt_en`=1, and phase X's lamp is on.
  - `ped_walk`=1 only in R_RUN.
  - Exactly one lamp is on in every non-FLASH state.
- Transitions:
  - IDLE -> G_LD when `run`=1.
  - Each X_LD -> X_RUN unconditionally. `cnt_last` is ignored in LD states.
  - G_RUN -> Y_LD when `cnt_last`=1, or when `ped_pending`=1 and `cnt_value` <= pGREEN_INIT_VAL - pMIN_GREEN.
  - Y_RUN -> R_LD when `cnt_last`=1.
  - R_RUN on `cnt_last`=1: -> G_LD if `run`=1, else -> IDLE.
- `run` is sampled only in IDLE and at the end of R_RUN. Deasserting it mid-cycle finishes green, yellow and red first.
- `ped_pending`:
  - Set on any cycle with `ped_req`=1.
  - Cleared on entry to Y_LD.
  - If set and clear happen in the same cycle, set wins, so the request is kept for the next green.
- FLASH:
  - `flash_req`=1 in any state -> FLASH at the next edge. This has priority over all other transitions.
  - In FLASH: `init`=0, `cnt_en`=0, green=0, red=0.
  - yellow toggles every pFLASH_HALF cycles, starting at 1 on entry, via an internal counter of width clog2(pFLASH_HALF).
  - `flash_req`=0 in FLASH -> R_LD, which is a safe restart through red.
- Arithmetic:
  - The threshold pGREEN_INIT_VAL - pMIN_GREEN is an elaboration constant. The compare is unsigned at pCNT_WIDTH.
  - pMIN_GREEN >= pGREEN_INIT_VAL disables early exit.

## Timing
- Reset values: state IDLE, red=1, green=0, yellow=0, `ped_walk`=0, `init`=0, `cnt_en`=0, `phase`=0, `ped_pending`=0, flash counter=0.
- Reset asserted mid-operation: outputs go to the reset values immediately (asynchronous). The first transition happens at the first edge after `rst` falls.
- All outputs are registered or decoded purely from the state; there are no combinational paths from inputs to outputs.
- Phase lengths with the default counter (14/2/17):
  - green = 1 LD + 15 RUN = 16 cycles
  - yellow = 4 cycles
  - red = 19 cycles
  - total period 39 cycles

## Test plan
- Reset, then `run`=1: IDLE (red) for 1 cycle, then `init`=001 for one cycle, green for 16 cycles, yellow for 4 (`init`=010 on its first cycle), red for 19 (`init`=100 on its first cycle) with `ped_walk`=1 for the last 18, then back to G_LD.
- `ped_req` pulse in the first G_RUN cycle (count=14): G_RUN exits when `cnt_value`=10, so green lasts 6 cycles and yellow follows. `ped_pending`=0 after Y_LD.
- `ped_req` held high through Y_LD: `ped_pending` stays 1, and the next green is cut short at count 10.
- `run` dropped during green: green, yellow and red complete, then IDLE with red=1, `cnt_en`=0, and no further `init` pulses.
- `flash_req` raised mid-yellow: next cycle `phase`=7, `cnt_en`=0, yellow pattern 8 on / 8 off. Releasing `flash_req` gives R_LD with `init`=100, then red runs for 19 cycles.
- `rst` asserted mid-red for 3 cycles: all outputs take their reset values asynchronously, and normal restart via IDLE follows after release.
